seq_mult_param: RTL and testbench



---
 rtl/seq_mult_param.sv | 128 ++++++++++++
 tb/tb_seq_mult_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Shift-and-add sequential multiplier, unsigned or two's-complement per transaction.
// Define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult_param #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH);
    localparam logic [2*WIDTH-1:0] ONE2     = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   prod_val;
    logic [WIDTH-1:0]     mb;
    logic [WIDTH-1:0]     mb_shift;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 neg;
    logic                 neg_in;
    logic                 accept;
    logic                 last;

    // Magnitude of -2^(W-1) is 2^(W-1), which still fits W unsigned bits
    always_comb begin
        a_mag    = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag    = (is_signed && b[WIDTH-1]) ? -b : b;
        neg_in   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_sum  = mb[0] ? (acc + mcand) : acc;
        mb_shift = mb >> 1;
        cnt_inc  = cnt + CNT_W'(1);
        prod_val = neg ? (~acc_sum + ONE2) : acc_sum;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        last     = (cnt_inc == CNT_LAST) || (mb_shift == '0);
`else
        last     = (cnt_inc == CNT_LAST);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    accept     = 1'b1;
                    state_next = MULT;
                end
            end
            MULT: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            mcand <= {{WIDTH{1'b0}}, a_mag};
            mb    <= b_mag;
            neg   <= neg_in;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == MULT) begin
            acc   <= acc_sum;
            mcand <= mcand << 1;
            mb    <= mb_shift;
            cnt   <= cnt_inc;
            if (last) begin
                product <= prod_val;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param (WIDTH=4): directed products, latency,
// back-to-back spacing, backpressure and asynchronous abort.
module tb_seq_mult_param;

    localparam int W = 4;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_valid = 1'b0;
    logic           is_signed = 1'b0;
    logic           result_ready = 1'b1;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           start_ready;
    logic           result_valid;
    logic           busy;
    logic [2*W-1:0] product;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic prev_rv = 1'b0;

    typedef struct {
        logic [2*W-1:0] p;
        int             lat;
        int             acc_cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0]   va;
        logic [W-1:0]   vb;
        logic           vs;
        logic [2*W-1:0] vp;
        int             lat_ee;
    } vec_t;

    exp_t sbq[$];

    vec_t vecs[13] = '{
        '{4'd9,  4'd13, 1'b0, 8'h75, 4},
        '{4'hD,  4'd5,  1'b1, 8'hF1, 3},
        '{4'h8,  4'h8,  1'b1, 8'h40, 4},
        '{4'd15, 4'd15, 1'b0, 8'hE1, 4},
        '{4'd7,  4'd1,  1'b0, 8'h07, 1},
        '{4'd7,  4'd0,  1'b0, 8'h00, 1},
        '{4'd7,  4'h8,  1'b1, 8'hC8, 4},
        '{4'hF,  4'hF,  1'b1, 8'h01, 1},
        '{4'd12, 4'd10, 1'b0, 8'h78, 4},
        '{4'd6,  4'hE,  1'b1, 8'hF4, 2},
        '{4'd0,  4'h9,  1'b1, 8'h00, 3},
        '{4'd3,  4'd3,  1'b0, 8'h09, 2},
        '{4'd5,  4'd3,  1'b1, 8'h0F, 2}
    };

    seq_mult_param #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .is_signed    (is_signed),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int ee_lat);
        return EE ? ee_lat : W;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic [2*W-1:0] tp,
                         input int tl, output int acyc);
        bit ok;
        ok = 1'b0;
        a = ta;
        b = tb_;
        is_signed = ts;
        start_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (start_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("start_timeout", 0, 1);
            start_valid = 1'b0;
            acyc = cyc;
            return;
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = 4'hA;
        b = 4'h5;
        is_signed = ~ts;
        acyc = cyc;
        sbq.push_back('{tp, tl, cyc});
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv <= 1'b0;
        end else begin
            if (result_valid && !prev_rv) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("latency", cyc - sbq[0].acc_cyc, sbq[0].lat);
                    chk("ready_excl", start_ready, 0);
                end
            end
            if (result_valid && result_ready && sbq.size() > 0) begin
                chk("product", product, sbq[0].p);
                void'(sbq.pop_front());
            end
            prev_rv <= result_valid;
        end
    end

    initial begin
        int acyc;
        int prev_acyc;
        int prev_lat;
        bit ok;

        #1;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        prev_acyc = 0;
        prev_lat = 0;
        foreach (vecs[i]) begin
            issue(vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].vp,
                  lat_of(vecs[i].lat_ee), acyc);
            if (i > 0) chk("accept_interval", acyc - prev_acyc, prev_lat + 2);
            prev_acyc = acyc;
            prev_lat = lat_of(vecs[i].lat_ee);
        end
        drain();

        // Backpressure with an ignored start while stalled in DONE
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        issue(4'd9, 4'd13, 1'b0, 8'h75, lat_of(4), acyc);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("bp_timeout", 0, 1);
        @(posedge clk);
        #1;
        a = 4'd3;
        b = 4'd3;
        is_signed = 1'b0;
        start_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", result_valid, 1);
            chk("bp_product", product, 8'h75);
            chk("bp_start_ready", start_ready, 0);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_ready", start_ready, 1);
        chk("bp_idle_valid", result_valid, 0);
        repeat (3) @(negedge clk);
        chk("bp_no_queue", busy, 0);

        // Asynchronous abort during the second MULT cycle
        @(posedge clk);
        #1;
        issue(4'd5, 4'd5, 1'b0, 8'h19, lat_of(3), acyc);
        @(posedge clk);
        #1;
        chk("hold_product", product, 8'h75);
        chk("mult_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_product", product, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_ready", start_ready, 1);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(4'd3, 4'd3, 1'b0, 8'h09, lat_of(2), acyc);
        drain();

        chk("queue_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
